axi4_lite_master_if: RTL and testbench

//  Converts simple request/done transfers into AXI4-Lite master transactions.

---
 rtl/axi4_lite_pkg.sv | 30 +++
 rtl/axi4_lite_master_if.sv | 138 +++++++++++++
 tb/tb_axi4_lite_master_if.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM states, default PROT.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WRESP,
    ST_RA,
    ST_RD,
    ST_DONE
  } state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    case (resp)
      RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
      RESP_SLVERR, RESP_DECERR: err = 1'b1;
      default:                  err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite master: turns level write/read requests into single AXI transactions,
// one outstanding at a time, and reports completion with a one-cycle oDONE pulse.
module axi4_lite_master_if
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    w_REQ,
  input  logic                    r_REQ,
  input  logic [ADDR_WIDTH-1:0]   w_ADDR,
  input  logic [DATA_WIDTH-1:0]   w_DATA,
  input  logic [ADDR_WIDTH-1:0]   r_ADDR,
  output logic                    oDONE,
  output logic                    oERR,
  output logic [DATA_WIDTH-1:0]   r_DATA,
  output logic [ADDR_WIDTH-1:0]   M_AWADDR,
  output logic [2:0]              M_AWPROT,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_ARADDR,
  output logic [2:0]              M_ARPROT,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic                    M_RREADY
);

  state_t                  state;
  logic                    aw_done;
  logic                    w_done;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    aw_fire;
  logic                    w_fire;

  assign aw_fire = M_AWVALID & M_AWREADY;
  assign w_fire  = M_WVALID & M_WREADY;

  // One latched address serves both channels since only one transfer is in flight.
  assign M_AWADDR = addr_q;
  assign M_ARADDR = addr_q;
  assign M_WDATA  = data_q;
  assign M_WSTRB  = '1;
  assign M_AWPROT = PROT_DEFAULT;
  assign M_ARPROT = PROT_DEFAULT;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state     <= ST_IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      r_DATA    <= '0;
      oDONE     <= 1'b0;
      oERR      <= 1'b0;
      M_AWVALID <= 1'b0;
      M_WVALID  <= 1'b0;
      M_BREADY  <= 1'b0;
      M_ARVALID <= 1'b0;
      M_RREADY  <= 1'b0;
    end else begin
      oDONE <= 1'b0;
      oERR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (w_REQ) begin
            addr_q    <= w_ADDR;
            data_q    <= w_DATA;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            M_AWVALID <= 1'b1;
            M_WVALID  <= 1'b1;
            state     <= ST_WR;
          end else if (r_REQ) begin
            addr_q    <= r_ADDR;
            M_ARVALID <= 1'b1;
            state     <= ST_RA;
          end
        end
        ST_WR: begin
          if (aw_fire) begin
            M_AWVALID <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_fire) begin
            M_WVALID <= 1'b0;
            w_done   <= 1'b1;
          end
          // Both handshakes may land in the same cycle, or in either order.
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            M_BREADY <= 1'b1;
            state    <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (M_BVALID) begin
            M_BREADY <= 1'b0;
            oDONE    <= 1'b1;
            oERR     <= resp_is_err(M_BRESP);
            state    <= ST_DONE;
          end
        end
        ST_RA: begin
          if (M_ARREADY) begin
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b1;
            state     <= ST_RD;
          end
        end
        ST_RD: begin
          if (M_RVALID) begin
            M_RREADY <= 1'b0;
            r_DATA   <= M_RDATA;
            oDONE    <= 1'b1;
            oERR     <= resp_is_err(M_RRESP);
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_if.sv
// Bench: acts as upstream requester and AXI slave; a transaction-level model
// predicts every channel output and completion each cycle.
module tb_axi4_lite_master_if;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        w_REQ = 1'b0, r_REQ = 1'b0;
  logic [31:0] w_ADDR = '0, w_DATA = '0, r_ADDR = '0;
  logic        oDONE, oERR;
  logic [31:0] r_DATA;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
  logic [2:0]  M_AWPROT, M_ARPROT;
  logic [3:0]  M_WSTRB;
  logic        M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY;
  logic        M_AWREADY = 1'b0, M_WREADY = 1'b0, M_BVALID = 1'b0;
  logic        M_ARREADY = 1'b0, M_RVALID = 1'b0;
  logic [1:0]  M_BRESP = '0, M_RRESP = '0;

  always #5 iCLK = ~iCLK;

  axi4_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .w_REQ(w_REQ), .r_REQ(r_REQ), .w_ADDR(w_ADDR), .w_DATA(w_DATA), .r_ADDR(r_ADDR),
    .oDONE(oDONE), .oERR(oERR), .r_DATA(r_DATA),
    .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state
  bit          chk_en = 0;
  bit          busy = 0, wr_txn = 0;
  bit          aw_hs, w_hs, ar_hs, b_hs, r_hs;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [31:0] exp_addr, exp_data;
  bit          done_pend = 0, err_pend = 0, done_rd_pend = 0;
  logic [31:0] rdata_pend = '0, model_rdata = '0;

  // Slave behaviour for the current transaction
  int          cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
  logic [1:0]  cfg_resp;
  logic [31:0] cfg_rdata;

  initial begin
    bit e_aw, e_w, e_b, e_ar, e_r, nd, ne, nrd;
    forever begin
      @(negedge iCLK);
      #1;
      if (iRST && chk_en) begin
        e_aw = busy && wr_txn && !aw_hs;
        e_w  = busy && wr_txn && !w_hs;
        e_b  = busy && wr_txn && aw_hs && w_hs && !b_hs;
        e_ar = busy && !wr_txn && !ar_hs;
        e_r  = busy && !wr_txn && ar_hs && !r_hs;

        check("oDONE", oDONE, done_pend);
        check("oERR", oERR, done_pend && err_pend);
        if (done_pend && done_rd_pend) model_rdata = rdata_pend;
        check("r_DATA", r_DATA, model_rdata);
        check("AWVALID", M_AWVALID, e_aw);
        check("WVALID", M_WVALID, e_w);
        check("BREADY", M_BREADY, e_b);
        check("ARVALID", M_ARVALID, e_ar);
        check("RREADY", M_RREADY, e_r);
        if (e_aw) begin
          check("AWADDR", M_AWADDR, exp_addr);
          check("AWPROT", M_AWPROT, 3'b000);
        end
        if (e_w) begin
          check("WDATA", M_WDATA, exp_data);
          check("WSTRB", M_WSTRB, 4'hF);
        end
        if (e_ar) begin
          check("ARADDR", M_ARADDR, exp_addr);
          check("ARPROT", M_ARPROT, 3'b000);
        end

        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_ARREADY = 0; M_RVALID = 0;
        M_BRESP = 2'($urandom); M_RRESP = 2'($urandom); M_RDATA = $urandom;
        nd = 0; ne = 0; nrd = 0;
        if (e_aw) begin
          if (aw_cnt > 0) aw_cnt--; else begin M_AWREADY = 1; aw_hs = 1; end
        end
        if (e_w) begin
          if (w_cnt > 0) w_cnt--; else begin M_WREADY = 1; w_hs = 1; end
        end
        if (e_b) begin
          if (b_cnt > 0) b_cnt--;
          else begin
            M_BVALID = 1; M_BRESP = cfg_resp; b_hs = 1;
            nd = 1; ne = (cfg_resp >= 2'd2);
          end
        end
        if (e_ar) begin
          if (ar_cnt > 0) ar_cnt--; else begin M_ARREADY = 1; ar_hs = 1; end
        end
        if (e_r) begin
          if (r_cnt > 0) r_cnt--;
          else begin
            M_RVALID = 1; M_RRESP = cfg_resp; M_RDATA = cfg_rdata; r_hs = 1;
            nd = 1; ne = (cfg_resp >= 2'd2); nrd = 1; rdata_pend = cfg_rdata;
          end
        end

        // Completion frees the master after one idle cycle; a request seen then is taken.
        if (done_pend) busy = 0;
        else if (!busy && (w_REQ || r_REQ)) begin
          busy = 1;
          wr_txn = w_REQ;
          exp_addr = w_REQ ? w_ADDR : r_ADDR;
          exp_data = w_DATA;
          aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
          aw_cnt = cfg_aw; w_cnt = cfg_w; b_cnt = cfg_b; ar_cnt = cfg_ar; r_cnt = cfg_r;
        end
        done_pend = nd; err_pend = ne; done_rd_pend = nrd;
      end
    end
  end

  task automatic run_txn(input bit do_w, input bit do_r, input logic [31:0] wa, input logic [31:0] wd,
                         input logic [31:0] ra, input int daw, input int dw, input int db,
                         input int dar, input int dr, input logic [1:0] resp,
                         input logic [31:0] rdat, input int gap, input bit scramble,
                         output int lat);
    if (gap > 0) begin
      w_REQ = 0; r_REQ = 0;
      repeat (gap) @(negedge iCLK);
    end
    cfg_aw = daw; cfg_w = dw; cfg_b = db; cfg_ar = dar; cfg_r = dr;
    cfg_resp = resp; cfg_rdata = rdat;
    w_REQ = do_w; r_REQ = do_r; w_ADDR = wa; w_DATA = wd; r_ADDR = ra;
    lat = 0;
    forever begin
      @(negedge iCLK);
      lat++;
      if (oDONE) break;
      if (lat > 300) begin
        checks++; errors++;
        $display("FAIL txn_timeout: got no oDONE expected oDONE within 300 cycles");
        break;
      end
      // Inputs seen outside IDLE must not matter once the transfer is accepted.
      if (scramble && lat >= 2) begin
        w_ADDR = $urandom; w_DATA = $urandom; r_ADDR = $urandom;
        w_REQ = 1'($urandom); r_REQ = 1'($urandom);
      end
    end
  endtask

  initial begin
    int lat;
    bit dw, dr;
    repeat (3) @(negedge iCLK);
    #1;
    check("rst_awvalid", M_AWVALID, 0);
    check("rst_wvalid", M_WVALID, 0);
    check("rst_arvalid", M_ARVALID, 0);
    check("rst_ready", {M_BREADY, M_RREADY}, 0);
    check("rst_done", {oDONE, oERR}, 0);
    check("rst_rdata", r_DATA, 0);
    @(negedge iCLK);
    iRST = 1; chk_en = 1;

    // Immediate slave write
    run_txn(1, 0, 32'h104, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2, 0, lat);
    check("t1_latency", lat, 3);
    check("t1_err", oERR, 0);
    // Skewed AW/W ready
    run_txn(1, 0, 32'h200, 32'hCAFEF00D, 0, 1, 4, 0, 0, 0, 2'b00, 0, 2, 0, lat);
    check("t2_latency", lat, 7);
    // Read with data two cycles late, then a write must leave r_DATA alone
    run_txn(0, 1, 0, 0, 32'h0A0, 0, 0, 0, 0, 2, 2'b00, 32'h12345678, 2, 0, lat);
    check("t3_latency", lat, 5);
    check("t3_rdata", r_DATA, 32'h12345678);
    run_txn(1, 0, 32'h300, 32'h55AA55AA, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, lat);
    check("t3_rdata_held", r_DATA, 32'h12345678);
    // Error responses
    run_txn(1, 0, 32'h400, 32'h1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 1, 0, lat);
    check("t4_slverr", oERR, 1);
    run_txn(0, 1, 0, 0, 32'h404, 0, 0, 0, 0, 0, 2'b11, 32'hA5A5A5A5, 0, 0, lat);
    check("t4_decerr", oERR, 1);
    run_txn(0, 1, 0, 0, 32'h408, 0, 0, 0, 1, 0, 2'b00, 32'h0BADF00D, 0, 0, lat);
    check("t4_okay", oERR, 0);
    check("t4_rdata", r_DATA, 32'h0BADF00D);
    run_txn(1, 0, 32'h40C, 32'h2, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, lat);
    check("t4_exokay", oERR, 0);
    // Both requests: write wins, read follows only after completion
    run_txn(1, 1, 32'h500, 32'h77, 32'h504, 0, 0, 0, 0, 0, 2'b00, 0, 2, 0, lat);
    check("t5_latency", lat, 3);
    check("t5_rdata", r_DATA, 32'h0BADF00D);
    run_txn(0, 1, 0, 0, 32'h504, 0, 0, 0, 0, 0, 2'b00, 32'h600DCAFE, 0, 0, lat);
    check("t5_read", r_DATA, 32'h600DCAFE);

    // Asynchronous reset while WVALID is held
    cfg_aw = 0; cfg_w = 20; cfg_b = 0; cfg_ar = 0; cfg_r = 0; cfg_resp = 0; cfg_rdata = 0;
    w_REQ = 1; r_REQ = 0; w_ADDR = 32'h600; w_DATA = 32'h12;
    repeat (4) @(negedge iCLK);
    #2;
    check("t6_wvalid_before", M_WVALID, 1);
    #1;
    iRST = 0;
    w_REQ = 0;
    M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_ARREADY = 0; M_RVALID = 0;
    busy = 0; done_pend = 0; err_pend = 0; done_rd_pend = 0; model_rdata = 0;
    #1;
    check("t6_valids", {M_AWVALID, M_WVALID, M_ARVALID}, 0);
    check("t6_readies", {M_BREADY, M_RREADY}, 0);
    check("t6_rdata", r_DATA, 0);
    check("t6_done", oDONE, 0);
    repeat (2) @(negedge iCLK);
    iRST = 1;
    repeat (5) @(negedge iCLK);
    run_txn(0, 1, 0, 0, 32'h700, 0, 0, 0, 0, 0, 2'b00, 32'h13572468, 0, 0, lat);
    check("t6_recover_lat", lat, 3);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      dw = 1'($urandom);
      dr = dw ? 1'($urandom) : 1'b1;
      run_txn(dw, dr, $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), $urandom,
              $urandom_range(0, 2), 1, lat);
    end
    w_REQ = 0; r_REQ = 0;
    repeat (4) @(negedge iCLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
